uart_core: RTL and testbench

- Runtime-configurable full-duplex UART, successor to the fixed 8N1 UART.
- Adds programmable baud divisor, 5–8 data bits, none/even/odd parity and 1/2 stop bits.
- RX oversamples and validates mid-bit; TX and RX both use valid/ready handshakes.
- Reports parity, framing and overrun errors; sits between a register block and the pads.

---
 rtl/uart_pkg.sv | 44 ++++
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_core.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared state encodings and configuration decode helpers for uart_core.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  function automatic logic [3:0] dbits_count(input logic [1:0] cfg_dbits);
    return 4'd5 + {2'b00, cfg_dbits};
  endfunction

  function automatic logic [7:0] dbits_mask(input logic [1:0] cfg_dbits);
    return 8'hFF >> (3'd3 - {1'b0, cfg_dbits});
  endfunction

  // Encoding 3 is reserved and behaves as "no parity".
  function automatic parity_e parity_decode(input logic [1:0] cfg_parity);
    case (cfg_parity)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick divider: one-clk tick every max(div,1) clks, held at zero by clr.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_last;

  always_comb begin
    div_last = (div == '0) ? '0 : div - DIV_W'(1);
    // >= keeps the divider sane if div shrinks below the running count.
    tick     = !clr && (cnt_q >= div_last);
    if (clr || tick) cnt_d = '0;
    else             cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_core.sv
// Runtime-configurable full-duplex UART (5-8 data bits, parity, 1/2 stop bits).
// Define UART_LOOPBACK_EN to let cfg_loopback route txd into the receiver.
module uart_core
  import uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_dbits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic             cfg_loopback,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             txd,
  input  logic             rxd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_overrun
);

  localparam int               CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);

  tx_state_e        tx_state_q, tx_state_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [3:0]       tx_dbits_q, tx_dbits_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             tx_par_en_q, tx_par_en_d;
  logic             tx_par_bit_q, tx_par_bit_d;
  logic             tx_stop2_q, tx_stop2_d;
  logic             txd_q, txd_d;
  logic             tx_idle, tx_tick, tx_bit_end;
  logic [7:0]       tx_masked;
  parity_e          tx_par_mode;

  assign tx_idle  = (tx_state_q == TX_IDLE);
  assign tx_ready = tx_idle;
  assign txd      = txd_q;

  uart_baud_gen #(.DIV_W(DIV_W)) u_tx_baud (
    .clk, .reset_n, .clr(tx_idle), .div(cfg_div), .tick(tx_tick)
  );

  // NOTE: every variable written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_shift_d   = tx_shift_q;
    tx_dbits_d   = tx_dbits_q;
    tx_bit_d     = tx_bit_q;
    tx_cnt_d     = tx_cnt_q;
    tx_par_en_d  = tx_par_en_q;
    tx_par_bit_d = tx_par_bit_q;
    tx_stop2_d   = tx_stop2_q;
    tx_bit_end   = 1'b0;
    tx_par_mode  = parity_decode(cfg_parity);
    tx_masked    = tx_data & dbits_mask(cfg_dbits);

    if (tx_tick) begin
      if (tx_cnt_q == CNT_LAST) begin
        tx_bit_end = 1'b1;
        tx_cnt_d   = '0;
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end

    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_valid) begin
          tx_state_d   = TX_START;
          tx_shift_d   = tx_masked;
          tx_dbits_d   = dbits_count(cfg_dbits);
          tx_par_en_d  = (tx_par_mode != PAR_NONE);
          tx_par_bit_d = (^tx_masked) ^ (tx_par_mode == PAR_ODD);
          tx_stop2_d   = cfg_stop2;
          tx_bit_d     = '0;
        end
      end
      TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
      TX_DATA: if (tx_bit_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if ({1'b0, tx_bit_q} == tx_dbits_q - 4'd1) begin
          tx_bit_d   = '0;
          tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
        end
      end
      TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
      TX_STOP: if (tx_bit_end) begin
        if (tx_stop2_q && tx_bit_q == 3'd0) tx_bit_d   = 3'd1;
        else                                tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // txd is registered from the next state so the pad never sees decode glitches.
    case (tx_state_d)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = tx_shift_d[0];
      TX_PARITY: txd_d = tx_par_bit_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q   <= TX_IDLE;
      tx_shift_q   <= '0;
      tx_dbits_q   <= 4'd8;
      tx_bit_q     <= '0;
      tx_cnt_q     <= '0;
      tx_par_en_q  <= 1'b0;
      tx_par_bit_q <= 1'b0;
      tx_stop2_q   <= 1'b0;
      txd_q        <= 1'b1;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_shift_q   <= tx_shift_d;
      tx_dbits_q   <= tx_dbits_d;
      tx_bit_q     <= tx_bit_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_par_en_q  <= tx_par_en_d;
      tx_par_bit_q <= tx_par_bit_d;
      tx_stop2_q   <= tx_stop2_d;
      txd_q        <= txd_d;
    end
  end

  logic             rx_in, sync1_q, sync2_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [3:0]       rx_dbits_q, rx_dbits_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  parity_e          rx_par_mode_q, rx_par_mode_d;
  logic             rx_perr_q, rx_perr_d;
  logic             rx_tick, rx_sample, rx_done;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_parity_err_q, rx_parity_err_d;
  logic             rx_frame_err_q, rx_frame_err_d;
  logic             rx_overrun_q, rx_overrun_d;

`ifdef UART_LOOPBACK_EN
  assign rx_in = cfg_loopback ? txd_q : rxd;
`else
  logic unused_loopback;
  assign unused_loopback = cfg_loopback;
  assign rx_in           = rxd;
`endif

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_parity_err_q;
  assign rx_frame_err  = rx_frame_err_q;
  assign rx_overrun    = rx_overrun_q;

  uart_baud_gen #(.DIV_W(DIV_W)) u_rx_baud (
    .clk, .reset_n, .clr(1'b0), .div(cfg_div), .tick(rx_tick)
  );

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_shift_d    = rx_shift_q;
    rx_dbits_d    = rx_dbits_q;
    rx_bit_d      = rx_bit_q;
    rx_cnt_d      = rx_cnt_q;
    rx_par_mode_d = rx_par_mode_q;
    rx_perr_d     = rx_perr_q;
    rx_sample     = 1'b0;
    rx_done       = 1'b0;

    // The start bit is checked at mid-bit; every later sample is one bit period on.
    if (rx_tick && rx_state_q != RX_IDLE && rx_state_q != RX_BREAK) begin
      if (rx_cnt_q == ((rx_state_q == RX_START) ? CNT_MID : CNT_LAST)) begin
        rx_sample = 1'b1;
        rx_cnt_d  = '0;
      end else begin
        rx_cnt_d = rx_cnt_q + 1'b1;
      end
    end

    case (rx_state_q)
      RX_IDLE: if (rx_tick && !sync2_q) begin
        rx_state_d    = RX_START;
        rx_cnt_d      = '0;
        rx_bit_d      = '0;
        rx_shift_d    = '0;
        rx_perr_d     = 1'b0;
        rx_dbits_d    = dbits_count(cfg_dbits);
        rx_par_mode_d = parity_decode(cfg_parity);
      end
      RX_START: if (rx_sample) rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
      RX_DATA: if (rx_sample) begin
        rx_shift_d[rx_bit_q] = sync2_q;
        if ({1'b0, rx_bit_q} == rx_dbits_q - 4'd1) begin
          rx_bit_d   = '0;
          rx_state_d = (rx_par_mode_q != PAR_NONE) ? RX_PARITY : RX_STOP;
        end else begin
          rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      RX_PARITY: if (rx_sample) begin
        rx_perr_d  = sync2_q ^ (^rx_shift_q) ^ (rx_par_mode_q == PAR_ODD);
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_sample) begin
        rx_done    = 1'b1;
        rx_state_d = sync2_q ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: if (sync2_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A full holding register drops the new word unless it is being popped this clk.
  always_comb begin
    rx_data_d       = rx_data_q;
    rx_valid_d      = rx_valid_q;
    rx_parity_err_d = rx_parity_err_q;
    rx_frame_err_d  = rx_frame_err_q;
    rx_overrun_d    = 1'b0;
    if (rx_done) begin
      if (rx_valid_q && !rx_ready) begin
        rx_overrun_d = 1'b1;
      end else begin
        rx_data_d       = rx_shift_q;
        rx_parity_err_d = rx_perr_q;
        rx_frame_err_d  = !sync2_q;
        rx_valid_d      = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      rx_state_q      <= RX_IDLE;
      rx_shift_q      <= '0;
      rx_dbits_q      <= 4'd8;
      rx_bit_q        <= '0;
      rx_cnt_q        <= '0;
      rx_par_mode_q   <= PAR_NONE;
      rx_perr_q       <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_overrun_q    <= 1'b0;
    end else begin
      sync1_q         <= rx_in;
      sync2_q         <= sync1_q;
      rx_state_q      <= rx_state_d;
      rx_shift_q      <= rx_shift_d;
      rx_dbits_q      <= rx_dbits_d;
      rx_bit_q        <= rx_bit_d;
      rx_cnt_q        <= rx_cnt_d;
      rx_par_mode_q   <= rx_par_mode_d;
      rx_perr_q       <= rx_perr_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rx_parity_err_q <= rx_parity_err_d;
      rx_frame_err_q  <= rx_frame_err_d;
      rx_overrun_q    <= rx_overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: stimulus queues expected TX frames and RX words,
// independent monitors pop and compare them as the DUT produces output.
`timescale 1ns/1ps
module tb_uart_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_dbits, cfg_parity;
  logic        cfg_stop2, cfg_loopback;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, txd;
  logic        rxd, rxd_drv, tb_loop;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready, rx_parity_err, rx_frame_err, rx_overrun;

  // External wire loop (txd -> rxd) so the default build can receive its own frames.
  assign rxd = tb_loop ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_core #(.DIV_W(16), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_div(cfg_div), .cfg_dbits(cfg_dbits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .cfg_loopback(cfg_loopback),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd),
    .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_exp_t;

  // bits[i] is the i-th line bit of the frame, start bit first; aborted frames skip the length check.
  typedef struct {
    logic [11:0] bits;
    int          nbits;
    bit          abort;
  } tx_exp_t;

  rx_exp_t rx_q[$];
  tx_exp_t tx_q[$];
  int      checks = 0;
  int      failures = 0;
  int      overrun_cnt = 0;
  logic    prev_valid = 1'b0;
  logic    prev_pop = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_rx(input logic [7:0] d, input logic perr, input logic ferr);
    rx_exp_t e;
    e.data = d;
    e.perr = perr;
    e.ferr = ferr;
    rx_q.push_back(e);
  endtask

  task automatic send_tx(input logic [7:0] d, input logic [11:0] bits, input int nbits,
                         input bit abort);
    tx_exp_t e;
    int w = 0;
    while (!tx_ready && w < 2000) begin
      clks(1);
      w++;
    end
    checks++;
    if (!tx_ready) begin
      failures++;
      $display("FAIL tx_ready_timeout: tx_ready still 0 after %0d clks", w);
    end
    e.bits  = bits;
    e.nbits = nbits;
    e.abort = abort;
    tx_q.push_back(e);
    tx_data  = d;
    tx_valid = 1'b1;
    clks(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_tx_done();
    int w = 0;
    while (!tx_ready && w < 2000) begin
      clks(1);
      w++;
    end
    checks++;
    if (!tx_ready) begin
      failures++;
      $display("FAIL tx_done_timeout: tx_ready still 0 after %0d clks", w);
    end
    clks(40);
  endtask

  // Drives one frame on rxd, 16 clks per bit (cfg_div=1). A 0 stop bit leaves the line low.
  task automatic drive_rx(input logic [7:0] d, input int nd, input bit has_par,
                          input logic par, input logic stop);
    rxd_drv = 1'b0;
    clks(16);
    for (int i = 0; i < nd; i++) begin
      rxd_drv = d[i];
      clks(16);
    end
    if (has_par) begin
      rxd_drv = par;
      clks(16);
    end
    rxd_drv = stop;
    clks(16);
  endtask

  // RX monitor: a word is new when rx_valid rises or reloads right after a pop.
  initial begin : rx_monitor
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_valid = 1'b0;
        prev_pop   = 1'b0;
      end else begin
        if (rx_valid && (!prev_valid || prev_pop)) begin
          if (rx_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected: got word 0x%0h, no word expected at %0t", rx_data, $time);
          end else begin
            e = rx_q.pop_front();
            check("rx_data", {24'h0, rx_data}, {24'h0, e.data});
            check("rx_parity_err", {31'h0, rx_parity_err}, {31'h0, e.perr});
            check("rx_frame_err", {31'h0, rx_frame_err}, {31'h0, e.ferr});
          end
        end
        prev_valid = rx_valid;
        prev_pop   = rx_valid && rx_ready;
        if (rx_overrun) overrun_cnt++;
      end
    end
  end

  // TX monitor: samples txd mid-bit (clk 8 of 16) and measures how long tx_ready stays low.
  initial begin : tx_monitor
    tx_exp_t te;
    int      k;
    forever begin
      @(negedge clk);
      if (reset_n && !tx_ready) begin
        if (tx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected: frame started with none expected at %0t", $time);
          te.bits  = '0;
          te.nbits = 0;
          te.abort = 1'b1;
        end else begin
          te = tx_q.pop_front();
        end
        k = 0;
        while (!tx_ready && k < 400) begin
          if (k % 16 == 8 && k / 16 < te.nbits)
            check($sformatf("txd_bit%0d", k / 16), {31'h0, txd}, {31'h0, te.bits[k/16]});
          k++;
          @(negedge clk);
        end
        if (!te.abort) check("tx_busy_clks", k, te.nbits * 16);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset_n      = 1'b0;
    cfg_div      = 16'd1;
    cfg_dbits    = 2'd3;
    cfg_parity   = 2'd0;
    cfg_stop2    = 1'b0;
    cfg_loopback = 1'b0;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    rxd_drv      = 1'b1;
    rx_ready     = 1'b1;
    tb_loop      = 1'b1;
    #23;
    check("reset_txd", {31'h0, txd}, 32'h1);
    check("reset_tx_ready", {31'h0, tx_ready}, 32'h1);
    check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_rx_data", {24'h0, rx_data}, 32'h0);
    check("reset_errs", {29'h0, rx_parity_err, rx_frame_err, rx_overrun}, 32'h0);
    reset_n = 1'b1;
    clks(5);

    // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1 (listed below stop..start)
    push_rx(8'hA5, 1'b0, 1'b0);
    send_tx(8'hA5, 12'b0011_0100_1010, 10, 1'b0);
    wait_tx_done();

    // 7E2 0x35: 0, 1,0,1,0,1,1,0, parity 0, 1,1 -> 11 bits, 176 clks
    cfg_dbits  = 2'd2;
    cfg_parity = 2'd1;
    cfg_stop2  = 1'b1;
    push_rx(8'h35, 1'b0, 1'b0);
    send_tx(8'h35, 12'b0110_0110_1010, 11, 1'b0);
    wait_tx_done();

    // 8O1 from the pin: 0x0F with wrong parity 0, then 0x3C with stop=0 (break)
    tb_loop    = 1'b0;
    cfg_dbits  = 2'd3;
    cfg_parity = 2'd2;
    cfg_stop2  = 1'b0;
    clks(20);
    push_rx(8'h0F, 1'b1, 1'b0);
    drive_rx(8'h0F, 8, 1'b1, 1'b0, 1'b1);
    clks(20);
    push_rx(8'h3C, 1'b0, 1'b1);
    drive_rx(8'h3C, 8, 1'b1, 1'b1, 1'b0);
    clks(300);
    rxd_drv = 1'b1;
    clks(40);
    push_rx(8'h42, 1'b0, 1'b0);
    drive_rx(8'h42, 8, 1'b1, 1'b1, 1'b1);
    clks(30);

    // Overrun: two frames with rx_ready low; only 0x11 is kept
    tb_loop     = 1'b1;
    cfg_parity  = 2'd0;
    rx_ready    = 1'b0;
    clks(10);
    overrun_cnt = 0;
    push_rx(8'h11, 1'b0, 1'b0);
    send_tx(8'h11, 12'b0010_0010_0010, 10, 1'b0);
    send_tx(8'h22, 12'b0010_0100_0100, 10, 1'b0);
    wait_tx_done();
    check("overrun_pulses", overrun_cnt, 1);
    check("overrun_valid_held", {31'h0, rx_valid}, 32'h1);
    check("overrun_data_kept", {24'h0, rx_data}, 32'h11);
    rx_ready = 1'b1;
    clks(1);
    check("rx_valid_drop", {31'h0, rx_valid}, 32'h0);

    // 4-clk glitch must not produce a word; a real frame afterwards must
    tb_loop = 1'b0;
    clks(10);
    rxd_drv = 1'b0;
    clks(4);
    rxd_drv = 1'b1;
    clks(60);
    push_rx(8'h81, 1'b0, 1'b0);
    drive_rx(8'h81, 8, 1'b0, 1'b0, 1'b1);
    clks(30);

    // Reset during data bit 3 of 0xC3, then a clean 0x5A frame
    tb_loop = 1'b1;
    send_tx(8'hC3, 12'b0000_0000_0110, 4, 1'b1);
    clks(16 * 4 + 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_txd", {31'h0, txd}, 32'h1);
    check("abort_tx_ready", {31'h0, tx_ready}, 32'h1);
    check("abort_rx_valid", {31'h0, rx_valid}, 32'h0);
    clks(3);
    reset_n = 1'b1;
    clks(5);
    push_rx(8'h5A, 1'b0, 1'b0);
    send_tx(8'h5A, 12'b0010_1011_0100, 10, 1'b0);
    wait_tx_done();

    clks(10);
    check("rx_queue_drained", rx_q.size(), 0);
    check("tx_queue_drained", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
